relu_serializer: RTL and testbench
==================================

// Module: relu_serializer
// PURPOSE
// - Sits between two linear_layer instances. Captures the parallel dout vector of one layer on its o_valid pulse.
// - Applies ReLU to each element, then streams the elements one per cycle into the next layer's serial din/i_valid port.
// - Also serves as the final stage: with ARGMAX compiled in, it reports the winning class index.
// PARAMETERS
// - DATA_WIDTH  24   element width; signed two's complement fixed point, matching linear_layer
// - NUM_NODES   500  vector length captured (upstream layer's NUM_NODES)
// PORTS
// - clk         in   1                       clock, rising edge
// - rst         in   1                       synchronous, active-high reset
// - i_valid     in   1                       one-cycle pulse; din holds a complete vector
// - din         in   DATA_WIDTH x NUM_NODES  unpacked array [NUM_NODES], upstream layer outputs
// - dout        out  DATA_WIDTH              current serialized element, after ReLU
// - o_valid     out  1                       dout valid, high for NUM_NODES consecutive cycles
// - o_first     out  1                       high with element 0; drives the downstream i_valid
// - o_last      out  1                       high with element NUM_NODES-1
// - o_busy      out  1                       vector held, streaming in progress
// - o_overflow  out  1                       sticky: an i_valid was dropped while busy
// - o_argmax    out  $clog2(NUM_NODES)       (ARGMAX only) index of the largest pre-ReLU element
// BEHAVIOUR
// - Reset values: dout=0, o_valid=0, o_first=0, o_last=0, o_busy=0, o_overflow=0, o_argmax=0, o_argmax_valid=0.
// - State machine, two states:
//   - IDLE: an i_valid pulse captures all din into a holding register; idx=0; go to STREAM.
//   - STREAM: emit one element per cycle, idx = 0..NUM_NODES-1. Return to IDLE after idx=NUM_NODES-1.
// - Latency: i_valid in cycle T gives element k on dout in cycle T+1+k. o_first is in T+1; o_last is in T+NUM_NODES.
// - Output registers:
//   - dout is registered: dout = hold[idx][DATA_WIDTH-1] ? '0 : hold[idx].
//   - Zero (0) passes through unchanged.
// - o_busy is 1 from cycle T+1 through the o_last cycle inclusive.
// - Accept rule:
//   - i_valid is accepted when o_busy=0, or when o_last=1 in the same cycle.
//   - Accepting on the o_last cycle gives a back-to-back stream with no bubble.
//   - A new vector accepted on the o_last cycle starts at element 0 the next cycle.
// - An i_valid at any other busy cycle is ignored and sets o_overflow. The stream in progress is unaffected.
// - o_overflow clears only on rst.
// - Counter idx is $clog2(NUM_NODES) bits; it never wraps past NUM_NODES-1.
// - NUM_NODES=1: o_first and o_last are both high in the same single cycle.
// - rst mid-stream: next cycle all outputs are at their reset values and the state is IDLE. The held vector is discarded.
// - rst has priority over i_valid in the same cycle.
// - o_valid, o_first and o_last are 0 whenever the state is IDLE.
// CONFIGURATION
// - RELU_SER_ARGMAX_EN defined:
//   - Running compare on the signed pre-ReLU value of each element as it streams. Strictly-greater replaces the current max, so ties keep the lowest index.
//   - o_argmax and o_argmax_valid are registered and appear in the cycle after o_last. o_argmax_valid is a one-cycle pulse.
//   - o_argmax holds its value until the next result or rst.
//   - The running max restarts at element 0 of each vector, including back-to-back vectors.
// - RELU_SER_ARGMAX_EN undefined: the o_argmax and o_argmax_valid ports and all compare logic are absent.
// TESTING (bench: DATA_WIDTH=8, NUM_NODES=4 unless stated)
// - Single vector:
//   - Stimulus: din={5,-3,0,127}, i_valid in cycle 10.
//   - Response: dout=5,0,0,127 in cycles 11-14; o_first at 11; o_last at 14; o_busy 11-14; then idle.
// - Back-to-back:
//   - Stimulus: second vector {1,2,3,4} with i_valid at cycle 14, the o_last cycle.
//   - Response: dout=1,2,3,4 in cycles 15-18; o_valid continuous 11-18; o_overflow=0.
// - Overflow:
//   - Stimulus: i_valid at cycle 12 while streaming.
//   - Response: the original stream completes unchanged; o_overflow=1 from cycle 13 and stays set until rst.
// - Reset mid-stream:
//   - Stimulus: rst at cycle 12, and i_valid in the same cycle.
//   - Response: cycle 13 has all outputs 0 and IDLE; no stream follows.
// - Argmax (RELU_SER_ARGMAX_EN):
//   - Stimulus: din={-8,-2,-2,-5}.
//   - Response: o_argmax=1 with o_argmax_valid the cycle after o_last; dout is all 0.
// - Argmax tie (RELU_SER_ARGMAX_EN):
//   - Stimulus: din={9,9,3,9}.
//   - Response: o_argmax=0.
// - Edge size:
//   - Stimulus: NUM_NODES=1, din={-1}.
//   - Response: dout=0 with o_first=o_last=o_valid=1 for one cycle.

Source files
------------

// File: rtl/relu_serializer.sv
// rtl/relu_serializer.sv - captures a parallel vector, applies ReLU, streams one element per cycle; optional argmax under RELU_SER_ARGMAX_EN
module relu_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_NODES  = 500,
  localparam int IDX_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] din [NUM_NODES],
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  o_valid,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_overflow
`ifdef RELU_SER_ARGMAX_EN
  ,
  output logic [IDX_W-1:0]      o_argmax,
  output logic                  o_argmax_valid
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic                  at_last;
  logic                  accept;
  logic                  drop;
  logic [DATA_WIDTH-1:0] hold [NUM_NODES];

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? '0 : x;
  endfunction

  // State and element index register; idx always names the element currently on dout
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next state, accept/drop decisions; a vector is accepted when idle or on the last element
  always_comb begin
    state_next = state;
    idx_next   = idx;
    at_last    = (state == STREAM) && (idx == LAST_IDX);
    accept     = i_valid && ((state == IDLE) || at_last);
    drop       = i_valid && (state == STREAM) && !at_last;
    if (accept) begin
      state_next = STREAM;
      idx_next   = '0;
    end else if (state == STREAM) begin
      if (at_last) begin
        state_next = IDLE;
        idx_next   = '0;
      end else begin
        idx_next = idx + 1'b1;
      end
    end
  end

  // Holding register; contents are don't-care outside a stream so no reset is needed
  always_ff @(posedge clk) begin
    if (accept) begin
      hold <= din;
    end
  end

  // Registered stream outputs; element 0 comes straight from din so it appears the cycle after capture
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      o_valid    <= 1'b0;
      o_first    <= 1'b0;
      o_last     <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (accept) begin
        dout    <= relu(din[0]);
        o_valid <= 1'b1;
        o_first <= 1'b1;
        o_last  <= (NUM_NODES == 1);
        o_busy  <= 1'b1;
      end else if ((state == STREAM) && !at_last) begin
        dout    <= relu(hold[idx_next]);
        o_first <= 1'b0;
        o_last  <= (idx_next == LAST_IDX);
      end else begin
        dout    <= '0;
        o_valid <= 1'b0;
        o_first <= 1'b0;
        o_last  <= 1'b0;
        o_busy  <= 1'b0;
      end
      if (drop) begin
        o_overflow <= 1'b1;
      end
    end
  end

`ifdef RELU_SER_ARGMAX_EN
  logic [DATA_WIDTH-1:0] max_val, best_val;
  logic [IDX_W-1:0]      max_idx, best_idx;
  logic                  take_cur;

  // Running maximum including the element on dout now; element 0 always restarts the search
  always_comb begin
    take_cur = o_first || ($signed(hold[idx]) > $signed(max_val));
    best_val = take_cur ? hold[idx] : max_val;
    best_idx = take_cur ? idx : max_idx;
  end

  // Track the max while streaming and publish the winner the cycle after the last element
  always_ff @(posedge clk) begin
    if (rst) begin
      max_val        <= '0;
      max_idx        <= '0;
      o_argmax       <= '0;
      o_argmax_valid <= 1'b0;
    end else begin
      o_argmax_valid <= 1'b0;
      if (state == STREAM) begin
        max_val <= best_val;
        max_idx <= best_idx;
        if (at_last) begin
          o_argmax       <= best_idx;
          o_argmax_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_relu_serializer.sv
// tb/tb_relu_serializer.sv - directed self-checking bench for relu_serializer (argmax cases under RELU_SER_ARGMAX_EN)
module tb_relu_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic [7:0] din [4];
  logic [7:0] dout;
  logic       o_valid, o_first, o_last, o_busy, o_overflow;

  logic       i_valid1;
  logic [7:0] din1 [1];
  logic [7:0] dout1;
  logic       o_valid1, o_first1, o_last1, o_busy1, o_overflow1;

`ifdef RELU_SER_ARGMAX_EN
  logic [1:0] o_argmax;
  logic       o_argmax_valid;
  logic [0:0] o_argmax1;
  logic       o_argmax_valid1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  relu_serializer #(.DATA_WIDTH(8), .NUM_NODES(4)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .din(din), .dout(dout),
    .o_valid(o_valid), .o_first(o_first), .o_last(o_last), .o_busy(o_busy),
    .o_overflow(o_overflow)
`ifdef RELU_SER_ARGMAX_EN
    , .o_argmax(o_argmax), .o_argmax_valid(o_argmax_valid)
`endif
  );

  relu_serializer #(.DATA_WIDTH(8), .NUM_NODES(1)) u_one (
    .clk(clk), .rst(rst), .i_valid(i_valid1), .din(din1), .dout(dout1),
    .o_valid(o_valid1), .o_first(o_first1), .o_last(o_last1), .o_busy(o_busy1),
    .o_overflow(o_overflow1)
`ifdef RELU_SER_ARGMAX_EN
    , .o_argmax(o_argmax1), .o_argmax_valid(o_argmax_valid1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic set_din(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic f,
                         input logic l, input logic b);
    check({tag, "_dout"},  {24'd0, dout}, {24'd0, d});
    check({tag, "_valid"}, {31'd0, o_valid}, {31'd0, v});
    check({tag, "_first"}, {31'd0, o_first}, {31'd0, f});
    check({tag, "_last"},  {31'd0, o_last},  {31'd0, l});
    check({tag, "_busy"},  {31'd0, o_busy},  {31'd0, b});
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
    check({tag, "_ovf"}, {31'd0, o_overflow}, {31'd0, exp});
  endtask

  // Drives vector {5,-3,0,127} with i_valid in the current cycle
  task automatic send_a();
    set_din(8'd5, 8'hFD, 8'd0, 8'd127);
    i_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_valid1 = 1'b0;
    set_din(8'd0, 8'd0, 8'd0, 8'd0);
    din1[0] = 8'd0;
    repeat (3) next_cycle();
    chk_out("reset", 8'd0, 0, 0, 0, 0);
    chk_ovf("reset", 0);
    rst = 1'b0;
    next_cycle();

    // Single vector, din scrambled after capture to prove the held copy is used
    send_a();
    next_cycle(); i_valid = 1'b0; set_din(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    chk_out("t1_e0", 8'd5, 1, 1, 0, 1);
    next_cycle(); chk_out("t1_e1", 8'd0, 1, 0, 0, 1);
    next_cycle(); chk_out("t1_e2", 8'd0, 1, 0, 0, 1);
    next_cycle(); chk_out("t1_e3", 8'd127, 1, 0, 1, 1);
    next_cycle(); chk_out("t1_idle", 8'd0, 0, 0, 0, 0);
    chk_ovf("t1", 0);

    // Back-to-back: second vector accepted on the o_last cycle
    next_cycle(); send_a();
    next_cycle(); i_valid = 1'b0; chk_out("t2_a0", 8'd5, 1, 1, 0, 1);
    next_cycle(); chk_out("t2_a1", 8'd0, 1, 0, 0, 1);
    next_cycle(); chk_out("t2_a2", 8'd0, 1, 0, 0, 1);
    next_cycle(); chk_out("t2_a3", 8'd127, 1, 0, 1, 1);
    set_din(8'd1, 8'd2, 8'd3, 8'd4); i_valid = 1'b1;
    next_cycle(); i_valid = 1'b0; set_din(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    chk_out("t2_b0", 8'd1, 1, 1, 0, 1);
    next_cycle(); chk_out("t2_b1", 8'd2, 1, 0, 0, 1);
    next_cycle(); chk_out("t2_b2", 8'd3, 1, 0, 0, 1);
    next_cycle(); chk_out("t2_b3", 8'd4, 1, 0, 1, 1);
    next_cycle(); chk_out("t2_idle", 8'd0, 0, 0, 0, 0);
    chk_ovf("t2", 0);

    // Overflow: i_valid on element 1 is dropped, stream unchanged, flag sticky until rst
    next_cycle(); send_a();
    next_cycle(); i_valid = 1'b0; chk_out("t3_e0", 8'd5, 1, 1, 0, 1);
    chk_ovf("t3_e0", 0);
    next_cycle(); chk_out("t3_e1", 8'd0, 1, 0, 0, 1);
    set_din(8'd1, 8'd2, 8'd3, 8'd4); i_valid = 1'b1;
    next_cycle(); i_valid = 1'b0; chk_out("t3_e2", 8'd0, 1, 0, 0, 1);
    chk_ovf("t3_e2", 1);
    next_cycle(); chk_out("t3_e3", 8'd127, 1, 0, 1, 1);
    chk_ovf("t3_e3", 1);
    next_cycle(); chk_out("t3_idle", 8'd0, 0, 0, 0, 0);
    chk_ovf("t3_idle", 1);
    next_cycle(); chk_ovf("t3_hold", 1);
    rst = 1'b1;
    next_cycle(); rst = 1'b0;
    chk_ovf("t3_rst", 0);

    // Reset mid-stream with a simultaneous i_valid: reset wins, no stream follows
    next_cycle(); send_a();
    next_cycle(); i_valid = 1'b0; chk_out("t4_e0", 8'd5, 1, 1, 0, 1);
    next_cycle(); chk_out("t4_e1", 8'd0, 1, 0, 0, 1);
    rst = 1'b1; i_valid = 1'b1; set_din(8'd1, 8'd2, 8'd3, 8'd4);
    next_cycle(); rst = 1'b0; i_valid = 1'b0;
    chk_out("t4_rst", 8'd0, 0, 0, 0, 0);
    chk_ovf("t4_rst", 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); chk_out("t4_after", 8'd0, 0, 0, 0, 0);
    end

`ifdef RELU_SER_ARGMAX_EN
    // Argmax: all negative, largest is -2 first seen at index 1; tie vector follows back-to-back
    next_cycle(); set_din(8'hF8, 8'hFE, 8'hFE, 8'hFB); i_valid = 1'b1;
    next_cycle(); i_valid = 1'b0; chk_out("t5_e0", 8'd0, 1, 1, 0, 1);
    next_cycle(); chk_out("t5_e1", 8'd0, 1, 0, 0, 1);
    next_cycle(); chk_out("t5_e2", 8'd0, 1, 0, 0, 1);
    check("t5_amv_early", {31'd0, o_argmax_valid}, 32'd0);
    next_cycle(); chk_out("t5_e3", 8'd0, 1, 0, 1, 1);
    set_din(8'd9, 8'd9, 8'd3, 8'd9); i_valid = 1'b1;
    next_cycle(); i_valid = 1'b0;
    chk_out("t6_e0", 8'd9, 1, 1, 0, 1);
    check("t5_amv", {31'd0, o_argmax_valid}, 32'd1);
    check("t5_am", {30'd0, o_argmax}, 32'd1);
    next_cycle(); chk_out("t6_e1", 8'd9, 1, 0, 0, 1);
    check("t5_amv_pulse", {31'd0, o_argmax_valid}, 32'd0);
    check("t5_am_hold", {30'd0, o_argmax}, 32'd1);
    next_cycle(); chk_out("t6_e2", 8'd3, 1, 0, 0, 1);
    next_cycle(); chk_out("t6_e3", 8'd9, 1, 0, 1, 1);
    next_cycle(); chk_out("t6_idle", 8'd0, 0, 0, 0, 0);
    check("t6_amv", {31'd0, o_argmax_valid}, 32'd1);
    check("t6_am", {30'd0, o_argmax}, 32'd0);
`endif

    // Single-node instance: first and last coincide
    next_cycle(); din1[0] = 8'hFF; i_valid1 = 1'b1;
    next_cycle(); i_valid1 = 1'b0;
    check("t7_dout",  {24'd0, dout1}, 32'd0);
    check("t7_valid", {31'd0, o_valid1}, 32'd1);
    check("t7_first", {31'd0, o_first1}, 32'd1);
    check("t7_last",  {31'd0, o_last1}, 32'd1);
    check("t7_busy",  {31'd0, o_busy1}, 32'd1);
    next_cycle();
    check("t7_idle_valid", {31'd0, o_valid1}, 32'd0);
    check("t7_idle_busy",  {31'd0, o_busy1}, 32'd0);
    check("t7_ovf",        {31'd0, o_overflow1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
